// File: rtl/mac_window_acc_if.sv
// Beat-in / result-out bundle for the windowed MAC accumulator.
// The producer/consumer side (bench or upstream logic) uses the master
// modport; the accumulator itself uses the slave modport.
interface mac_window_acc_if #(
  parameter int PROD_W = 11,
  parameter int BIAS_W = 12,
  parameter int ACC_W  = 17,
  parameter int OUT_W  = 7
);
  logic                     win_clr;
  logic                     in_valid;
  logic                     in_ready;
  logic        [PROD_W-1:0] in_prod;
  logic                     in_neg;
  logic signed [BIAS_W-1:0] bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_raw;
  logic        [OUT_W-1:0]  out_act;

  modport master (
    output win_clr, in_valid, in_prod, in_neg, bias, out_ready,
    input  in_ready, out_valid, out_raw, out_act
  );

  modport slave (
    input  win_clr, in_valid, in_prod, in_neg, bias, out_ready,
    output in_ready, out_valid, out_raw, out_act
  );
endinterface

// File: rtl/mac_window_acc.sv
// Windowed multiply-accumulate consumer for the 7x4 approximate multiplier.
// Sums WIN signed products on top of a per-window bias, then presents the
// raw sum together with a ReLU'd, shifted, saturated activation that feeds
// the next layer's multiplier A operand.
module mac_window_acc #(
  parameter int PROD_W = 11,
  parameter int WIN    = 25,
  parameter int BIAS_W = 12,
  parameter int ACC_W  = 17,
  parameter int SHIFT  = 4,
  parameter int OUT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  mac_window_acc_if.slave   bus
);

  localparam int CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);
  localparam logic signed [ACC_W-1:0] ACT_MAX = ACC_W'((1 << OUT_W) - 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic        [CNT_W-1:0]  cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  raw;
  logic        [OUT_W-1:0]  act;
  logic                     ready;
  logic                     accept;
  logic                     last_beat;

  // Sign-extend the bias into the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_bias(
    input logic signed [BIAS_W-1:0] b
  );
    return {{(ACC_W-BIAS_W){b[BIAS_W-1]}}, b};
  endfunction

  // Zero-extend the unsigned product magnitude into the accumulator width.
  function automatic logic signed [ACC_W-1:0] zext_prod(
    input logic [PROD_W-1:0] p
  );
    return {{(ACC_W-PROD_W){1'b0}}, p};
  endfunction

  // ReLU, arithmetic shift down, then clamp to the unsigned activation range.
  function automatic logic [OUT_W-1:0] activate(
    input logic signed [ACC_W-1:0] s
  );
    logic signed [ACC_W-1:0] sh;
    sh = s >>> SHIFT;
    if (s[ACC_W-1]) begin
      return '0;
    end
    if (sh > ACT_MAX) begin
      return '1;
    end
    return sh[OUT_W-1:0];
  endfunction

  // The first beat of a window starts from the bias instead of the stale acc.
  always_comb begin
    base      = (cnt == '0) ? sext_bias(bus.bias) : acc;
    term      = bus.in_neg ? -zext_prod(bus.in_prod) : zext_prod(bus.in_prod);
    sum       = base + term;
    last_beat = (cnt == LAST_CNT);
    // win_clr wins over a beat arriving in the same cycle.
    accept    = bus.in_valid && ready && !bus.win_clr;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: collect until the last beat, hold until taken or cleared.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC: begin
        if (accept && last_beat) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.win_clr || bus.out_ready) begin
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  // Output logic: ready only while collecting and out of reset; valid in HOLD.
  always_comb begin
    ready         = (state == ACC) && !rst;
    bus.in_ready  = ready;
    bus.out_valid = (state == HOLD);
  end

  // Accumulator, beat counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      raw <= '0;
      act <= '0;
    end else if ((state == ACC) && bus.win_clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last_beat) begin
        acc <= '0;
        cnt <= '0;
        raw <= sum;
        act <= activate(sum);
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.out_raw = raw;
  assign bus.out_act = act;

endmodule

// File: tb/tb_mac_window_acc.sv
// Directed bench for mac_window_acc: table of full windows with hand-computed
// results, plus sequences for back-pressure, bubbles, win_clr and async reset.
module tb_mac_window_acc;

  localparam int PROD_W = 11;
  localparam int WIN    = 25;
  localparam int BIAS_W = 12;
  localparam int ACC_W  = 17;
  localparam int SHIFT  = 4;
  localparam int OUT_W  = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  mac_window_acc_if #(
    .PROD_W(PROD_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) bus ();

  mac_window_acc #(
    .PROD_W(PROD_W), .WIN(WIN), .BIAS_W(BIAS_W),
    .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [BIAS_W-1:0] bias;
    logic        [PROD_W-1:0] prod;
    logic                     neg;
    longint                   exp_raw;
    longint                   exp_act;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input longint act_v, input longint exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // One beat presented for exactly one cycle; caller guarantees in_ready.
  task automatic beat(input logic [PROD_W-1:0] p, input logic n,
                      input logic signed [BIAS_W-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_neg   = n;
    bus.bias     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Full window: bias only meaningful on beat 0, later beats carry junk bias.
  // Checks out_valid stays low until one cycle after the last beat.
  task automatic run_window(input logic signed [BIAS_W-1:0] b,
                            input logic [PROD_W-1:0] p, input logic n,
                            input bit bubbles);
    for (int i = 0; i < WIN; i++) begin
      if (bubbles && ($urandom_range(0, 2) == 0)) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) idle_cycle();
      end
      if (i == WIN - 1) chk("out_valid_before_last", 64'(bus.out_valid), 0);
      beat(p, n, (i == 0) ? b : BIAS_W'($urandom));
    end
    chk("out_valid_after_last", 64'(bus.out_valid), 1);
    chk("in_ready_in_hold", 64'(bus.in_ready), 0);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_after_take", 64'(bus.out_valid), 0);
    chk("in_ready_after_take", 64'(bus.in_ready), 1);
  endtask

  initial begin
    logic signed [ACC_W-1:0] held_raw;
    logic        [OUT_W-1:0] held_act;

    vecs[0] = '{bias: 12'sd0,    prod: 11'd10,   neg: 1'b0, exp_raw: 250,   exp_act: 15};
    vecs[1] = '{bias: -12'sd100, prod: 11'd3,    neg: 1'b1, exp_raw: -175,  exp_act: 0};
    vecs[2] = '{bias: 12'sd2047, prod: 11'd2047, neg: 1'b0, exp_raw: 53222, exp_act: 127};
    vecs[3] = '{bias: 12'sd32,   prod: 11'd80,   neg: 1'b0, exp_raw: 2032,  exp_act: 127};
    vecs[4] = '{bias: 12'sd0,    prod: 11'd82,   neg: 1'b0, exp_raw: 2050,  exp_act: 127};
    vecs[5] = '{bias: 12'sd0,    prod: 11'd0,    neg: 1'b0, exp_raw: 0,     exp_act: 0};
    vecs[6] = '{bias: -12'sd1,   prod: 11'd0,    neg: 1'b0, exp_raw: -1,    exp_act: 0};
    vecs[7] = '{bias: 12'sd15,   prod: 11'd0,    neg: 1'b1, exp_raw: 15,    exp_act: 0};
    vecs[8] = '{bias: 12'sd16,   prod: 11'd1,    neg: 1'b1, exp_raw: -9,    exp_act: 0};

    bus.win_clr   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_neg    = 1'b0;
    bus.bias      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    idle_cycle();
    idle_cycle();
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_raw", longint'(bus.out_raw), 0);
    chk("rst_out_act", 64'(bus.out_act), 0);
    chk("rst_in_ready_held", 64'(bus.in_ready), 0);
    rst = 1'b0;
    idle_cycle();
    chk("rst_in_ready_released", 64'(bus.in_ready), 1);

    // Table-driven windows
    foreach (vecs[i]) begin
      run_window(vecs[i].bias, vecs[i].prod, vecs[i].neg, 1'b0);
      chk($sformatf("vec%0d_raw", i), longint'(bus.out_raw), vecs[i].exp_raw);
      chk($sformatf("vec%0d_act", i), 64'(bus.out_act), vecs[i].exp_act);
      handshake();
    end

    // Back-pressure: 5 cycles of out_ready=0 with in_valid pushing junk
    run_window(12'sd0, 11'd10, 1'b0, 1'b0);
    held_raw = bus.out_raw;
    held_act = bus.out_act;
    chk("bp_raw_initial", longint'(held_raw), 250);
    bus.in_valid = 1'b1;
    bus.in_prod  = 11'd500;
    for (int c = 0; c < 5; c++) begin
      idle_cycle();
      chk("bp_in_ready", 64'(bus.in_ready), 0);
      chk("bp_out_valid", 64'(bus.out_valid), 1);
      chk("bp_raw_stable", longint'(bus.out_raw), 250);
      chk("bp_act_stable", 64'(bus.out_act), 15);
    end
    bus.in_valid = 1'b0;
    handshake();
    run_window(12'sd0, 11'd10, 1'b0, 1'b0);
    chk("bp_next_raw", longint'(bus.out_raw), 250);
    chk("bp_next_act", 64'(bus.out_act), 15);
    handshake();

    // Random in_valid bubbles
    run_window(12'sd0, 11'd10, 1'b0, 1'b1);
    chk("bubble_raw", longint'(bus.out_raw), 250);
    chk("bubble_act", 64'(bus.out_act), 15);
    handshake();

    // win_clr after 10 beats, colliding with a valid beat that must be dropped
    for (int i = 0; i < 10; i++) beat(11'd10, 1'b0, 12'sd0);
    bus.win_clr  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 11'd999;
    idle_cycle();
    bus.win_clr  = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_out_valid", 64'(bus.out_valid), 0);
    run_window(12'sd16, 11'd4, 1'b0, 1'b1);
    chk("clr_raw", longint'(bus.out_raw), 116);
    chk("clr_act", 64'(bus.out_act), 7);

    // win_clr in HOLD drops the pending result but keeps the output values
    bus.win_clr = 1'b1;
    idle_cycle();
    bus.win_clr = 1'b0;
    chk("clr_hold_out_valid", 64'(bus.out_valid), 0);
    chk("clr_hold_in_ready", 64'(bus.in_ready), 1);
    chk("clr_hold_raw_kept", longint'(bus.out_raw), 116);
    chk("clr_hold_act_kept", 64'(bus.out_act), 7);
    run_window(12'sd0, 11'd10, 1'b0, 1'b0);
    chk("post_clr_raw", longint'(bus.out_raw), 250);
    handshake();

    // Async reset mid-window after 12 beats
    for (int i = 0; i < 12; i++) beat(11'd10, 1'b0, 12'sd0);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 0);
    chk("arst_out_raw", longint'(bus.out_raw), 0);
    chk("arst_out_act", 64'(bus.out_act), 0);
    idle_cycle();
    rst = 1'b0;
    idle_cycle();
    chk("arst_in_ready", 64'(bus.in_ready), 1);
    run_window(12'sd0, 11'd10, 1'b0, 1'b0);
    chk("arst_next_raw", longint'(bus.out_raw), 250);
    chk("arst_next_act", 64'(bus.out_act), 15);
    handshake();

    // Async reset while holding a result
    run_window(12'sd2047, 11'd2047, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_hold_out_valid", 64'(bus.out_valid), 0);
    chk("arst_hold_raw", longint'(bus.out_raw), 0);
    idle_cycle();
    rst = 1'b0;
    idle_cycle();
    chk("arst_hold_in_ready", 64'(bus.in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
